// File: rtl/coax_tx_serializer.sv
// 3270 coax transmit serializer: takes 10-bit words over valid/ready and emits one
// Manchester-encoded frame (quiesce, code violation, sync/data/parity per word, end sequence).
module coax_tx_serializer #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx_active,
    output logic       tx
);

    localparam int HALF = CLOCKS_PER_BIT / 2;
    localparam int PW   = $clog2(CLOCKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE, ST_QUIESCE, ST_CODE_VIOL, ST_SYNC, ST_DATA, ST_PARITY, ST_END
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [9:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [9:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            ready_q, ready_d;
    logic            tx_q, tx_d;
    logic            act_q, act_d;
    logic            bit_end, load_sync, first_d;

    assign bit_end = (phase_q == PW'(CLOCKS_PER_BIT - 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bitcnt_d    = bitcnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        load_sync   = 1'b0;

        if (valid && ready_q) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        if (state_q == ST_IDLE) begin
            phase_d  = '0;
            bitcnt_d = '0;
            if (hold_full_q) state_d = ST_QUIESCE;
        end else begin
            phase_d = bit_end ? '0 : phase_q + PW'(1);
            if (bit_end) begin
                bitcnt_d = bitcnt_q + 4'd1;
                case (state_q)
                    ST_QUIESCE:   if (bitcnt_q == 4'd4) begin
                                      state_d  = ST_CODE_VIOL;
                                      bitcnt_d = '0;
                                  end
                    ST_CODE_VIOL: if (bitcnt_q == 4'd2) load_sync = 1'b1;
                    ST_SYNC: begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                    ST_DATA: begin
                        shift_d = {shift_q[8:0], 1'b0};
                        if (bitcnt_q == 4'd9) begin
                            state_d  = ST_PARITY;
                            bitcnt_d = '0;
                        end
                    end
                    ST_PARITY: begin
                        bitcnt_d = '0;
                        if (hold_full_q) load_sync = 1'b1;
                        else             state_d   = ST_END;
                    end
                    ST_END:       if (bitcnt_q == 4'd2) begin
                                      state_d  = ST_IDLE;
                                      bitcnt_d = '0;
                                  end
                    default:      state_d = ST_IDLE;
                endcase
            end
        end

        // Entering SYNC frees the holding register so the next word can chain into this frame.
        if (load_sync) begin
            state_d     = ST_SYNC;
            bitcnt_d    = '0;
            shift_d     = hold_q;
            par_d       = ^hold_q;
            hold_full_d = 1'b0;
        end
    end

    // Line level for the cycle the next-state values describe, so tx lands registered.
    always_comb begin
        first_d = (phase_d < PW'(HALF));
        tx_d    = 1'b0;
        case (state_d)
            ST_QUIESCE, ST_SYNC: tx_d = first_d;
            ST_CODE_VIOL:        tx_d = (bitcnt_d == 4'd0) || ((bitcnt_d == 4'd1) && first_d);
            ST_DATA:             tx_d = first_d ? shift_d[9] : ~shift_d[9];
            ST_PARITY:           tx_d = first_d ? par_d : ~par_d;
            ST_END:              tx_d = (bitcnt_d == 4'd0) ? ~first_d : 1'b1;
            default:             tx_d = 1'b0;
        endcase
        act_d   = (state_d != ST_IDLE);
        ready_d = ~hold_full_d && (state_d != ST_END);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bitcnt_q    <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            ready_q     <= 1'b0;
            tx_q        <= 1'b0;
            act_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bitcnt_q    <= bitcnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            act_q       <= act_d;
        end
    end

    assign ready     = ready_q;
    assign tx_active = act_q;
    assign tx        = tx_q;

endmodule

// File: tb/tb_coax_tx_serializer.sv
// Bench for coax_tx_serializer: table of frames compared clock-by-clock against a
// reference waveform, plus hand sequences for END back-pressure, valid glitch and mid-frame reset.
module tb_coax_tx_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] data8, data4;
    logic       valid8, valid4;
    logic       ready8, ready4, tx_active8, tx_active4, tx8, tx4;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    logic cap_q[$];
    logic exp_q[$];

    typedef struct {
        logic [9:0] w0;
        logic       p0;
        bit         two;
        logic [9:0] w1;
        logic       p1;
        int         len;
    } vec_t;

    vec_t vecs[5];

    coax_tx_serializer #(.CLOCKS_PER_BIT(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .data(data8), .valid(valid8),
        .ready(ready8), .tx_active(tx_active8), .tx(tx8));

    coax_tx_serializer #(.CLOCKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .data(data4), .valid(valid4),
        .ready(ready4), .tx_active(tx_active4), .tx(tx4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string name, input int act, input int req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ready4 : ready8;
    endfunction
    function automatic logic act(input bit sel);
        return sel ? tx_active4 : tx_active8;
    endfunction
    function automatic logic txv(input bit sel);
        return sel ? tx4 : tx8;
    endfunction

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic send(input bit sel, input logic [9:0] w, output int acc);
        int t = 0;
        if (sel) begin valid4 = 1'b1; data4 = w; end
        else     begin valid8 = 1'b1; data8 = w; end
        while (rdy(sel) !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
        if (rdy(sel) !== 1'b1) begin
            chk("send_timeout", 0, 1);
            acc = -1;
        end else begin
            @(posedge clk);
            @(negedge clk);
            acc = cyc;
            chk("rdy_drop", int'(rdy(sel)), 0);
        end
        if (sel) begin valid4 = 1'b0; data4 = ~w; end
        else     begin valid8 = 1'b0; data8 = ~w; end
    endtask

    task automatic wait_rdy_rise(input bit sel, input int a0);
        int t = 0;
        while (rdy(sel) !== 1'b1 && t < 500) begin @(negedge clk); t++; end
        chk("rdy_rise_at", cyc - a0, 65);
    endtask

    task automatic capture(input bit sel, output int rise);
        int t = 0;
        cap_q.delete();
        rise = -1;
        while (act(sel) !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
        if (act(sel) !== 1'b1) begin
            chk("cap_start", 0, 1);
        end else begin
            rise = cyc;
            t = 0;
            while (act(sel) === 1'b1 && t < 3000) begin
                cap_q.push_back(txv(sel));
                @(negedge clk);
                t++;
            end
        end
    endtask

    function automatic void push_bit(input int cpb, input logic b);
        for (int i = 0; i < cpb / 2; i++) exp_q.push_back(b);
        for (int i = 0; i < cpb / 2; i++) exp_q.push_back(~b);
    endfunction

    task automatic check_frame(input int cpb, input vec_t v);
        int mm = 0;
        int n;
        int idx;
        logic [9:0] w;
        exp_q.delete();
        for (int i = 0; i < 5; i++) push_bit(cpb, 1'b1);
        for (int i = 0; i < 3 * cpb / 2; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 3 * cpb / 2; i++) exp_q.push_back(1'b0);
        for (int k = 0; k < (v.two ? 2 : 1); k++) begin
            w = (k == 1) ? v.w1 : v.w0;
            push_bit(cpb, 1'b1);
            for (int i = 9; i >= 0; i--) push_bit(cpb, w[i]);
            push_bit(cpb, (k == 1) ? v.p1 : v.p0);
        end
        push_bit(cpb, 1'b0);
        for (int i = 0; i < 2 * cpb; i++) exp_q.push_back(1'b1);

        chk("frame_len", cap_q.size(), v.len);
        n = (cap_q.size() > exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= cap_q.size() || i >= exp_q.size() || cap_q[i] !== exp_q[i]) mm++;
        chk("wave_mismatches", mm, 0);
        idx = 19 * cpb + cpb / 4;
        chk("parity0", (idx < cap_q.size()) ? int'(cap_q[idx]) : -1, int'(v.p0));
        if (v.two) begin
            idx = 31 * cpb + cpb / 4;
            chk("parity1", (idx < cap_q.size()) ? int'(cap_q[idx]) : -1, int'(v.p1));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int a0 = 0;
        int a1 = 0;
        int rise = 0;
        fork
            begin
                send(1'b0, v.w0, a0);
                if (v.two) begin
                    send(1'b0, v.w1, a1);
                    chk("acc2_at", a1 - a0, 66);
                end else begin
                    wait_rdy_rise(1'b0, a0);
                end
            end
            capture(1'b0, rise);
        join
        chk("act_rise_at", rise - a0, 1);
        check_frame(8, v);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int a0, a1, rise, rise2, seen, ones;
        vec_t v;
        vecs[0] = '{10'h155, 1'b1, 1'b0, 10'h000, 1'b0, 184};
        vecs[1] = '{10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 184};
        vecs[2] = '{10'h3FF, 1'b0, 1'b1, 10'h001, 1'b1, 280};
        vecs[3] = '{10'h2C3, 1'b1, 1'b0, 10'h000, 1'b0, 184};
        vecs[4] = '{10'h0F0, 1'b0, 1'b0, 10'h000, 1'b0, 184};

        reset_n = 1'b0;
        valid8 = 1'b0; valid4 = 1'b0;
        data8 = '0; data4 = '0;
        #12;
        chk("reset_tx", int'(tx8), 0);
        chk("reset_act", int'(tx_active8), 0);
        chk("reset_rdy", int'(ready8), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_release", int'(ready8), 1);
        chk("rdy4_after_release", int'(ready4), 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // valid raised while ready is low, then dropped: must not be taken
        fork
            begin
                send(1'b0, 10'h155, a0);
                while (cyc < a0 + 10) @(negedge clk);
                valid8 = 1'b1; data8 = 10'h3FF;
                repeat (3) @(negedge clk);
                valid8 = 1'b0;
                wait_rdy_rise(1'b0, a0);
            end
            capture(1'b0, rise);
        join
        check_frame(8, vecs[0]);
        repeat (3) @(negedge clk);

        // word presented during END waits for IDLE and gets its own full frame
        fork
            begin
                send(1'b0, 10'h000, a0);
                while (cyc < a0 + 165) @(negedge clk);
                send(1'b0, 10'h3FF, a1);
                chk("end_accept_at", a1 - a0, 186);
            end
            begin
                capture(1'b0, rise);
                check_frame(8, vecs[1]);
                capture(1'b0, rise2);
                chk("frame2_rise_gap", rise2 - rise, 186);
                v = '{10'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 184};
                check_frame(8, v);
            end
        join
        repeat (3) @(negedge clk);

        // reset during DATA bit 4 with a second word pending
        send(1'b0, 10'h3FF, a0);
        while (cyc < a0 + 70) @(negedge clk);
        send(1'b0, 10'h155, a1);
        while (cyc < a0 + 106) @(negedge clk);
        chk("pre_rst_tx", int'(tx8), 1);
        chk("pre_rst_act", int'(tx_active8), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_tx", int'(tx8), 0);
        chk("rst_act", int'(tx_active8), 0);
        chk("rst_rdy", int'(ready8), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", int'(ready8), 1);
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_active8 === 1'b1) seen++;
        end
        chk("no_pending_frame", seen, 0);
        run_vec(vecs[3]);

        // narrow-bit instance
        v = '{10'h2AA, 1'b1, 1'b0, 10'h000, 1'b0, 92};
        fork
            send(1'b1, 10'h2AA, a0);
            capture(1'b1, rise);
        join
        chk("act4_rise_at", rise - a0, 1);
        check_frame(4, v);
        ones = 0;
        for (int i = 20; i < 26 && i < cap_q.size(); i++) ones += int'(cap_q[i]);
        chk("cv4_high_clocks", ones, 6);
        ones = 0;
        for (int i = 26; i < 32 && i < cap_q.size(); i++) ones += int'(cap_q[i] == 1'b0);
        chk("cv4_low_clocks", ones, 6);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/coax_tx_serializer.md
Name: coax_tx_serializer

Overview:
- Upstream neighbour of coax_tx_rx_frontend; drives its tx_active_input and tx_input.
- Accepts 10-bit coax words over a valid/ready handshake and builds one complete 3270 transmission.
- Transmission order: line quiesce, code violation, then per word a sync bit, 10 data bits and even parity, then an end sequence.
- Output is Manchester (bi-phase) encoded at CLOCKS_PER_BIT clocks per bit; back-to-back words share one frame.

Parameters:
- CLOCKS_PER_BIT, 8, clocks per bit time; must be even and >= 4. Half-bit = CLOCKS_PER_BIT/2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- data  input  10  word to transmit, MSB first
- valid  input  1  data is valid
- ready  output  1  holding register can accept a word
- tx_active  output  1  frame in progress; to frontend tx_active_input
- tx  output  1  encoded line level; to frontend tx_input

Behaviour:
- Reset (async, reset_n=0):
  - tx=0, tx_active=0, holding register empty, state IDLE, counters 0.
  - ready=1 from the first clock edge after reset_n releases.
- Encoding:
  - bit 1 = tx high for first half-bit, low for second.
  - bit 0 = tx low for first half-bit, high for second.
- Handshake:
  - Word accepted on a rising edge with valid && ready; data is latched into a 1-deep holding register.
  - ready = ~hold_full && state != END.
  - ready drops the cycle after acceptance.
- States:
  - IDLE: tx_active=0, tx=0. Go to QUIESCE the cycle after hold_full becomes 1; tx_active=1 from that cycle.
  - QUIESCE: 5 bit times of encoded 1s.
  - CODE_VIOLATION: tx=1 for 3 half-bits, then tx=0 for 3 half-bits (3 bit times in total).
  - SYNC: 1 bit time of encoded 1. On entry, the holding register moves to the shifter; hold_full clears and ready rises the same cycle.
  - DATA: 10 bits from the shifter, MSB first.
  - PARITY: 1 bit, even parity, so ones in data plus parity is even. At the last clock of PARITY:
    - hold_full=1 -> SYNC (next word, no quiesce or code violation);
    - otherwise -> END.
  - END: encoded 0 bit, then tx=1 for 2 bit times, then IDLE; tx=0 and tx_active=0 on the IDLE cycle.
- Frame timing:
  - Single-word frame: tx_active high for exactly (5+3+12+3)*CLOCKS_PER_BIT clocks = 184 at default.
  - Each extra chained word adds 12*CLOCKS_PER_BIT.
- Boundary conditions:
  - A word arriving in END waits (ready=0); it starts a new frame with full quiesce after IDLE.
  - valid dropping before acceptance has no effect.
  - data changes after acceptance are ignored.
  - reset_n low mid-frame: outputs go to reset values immediately; the pending word is discarded.
- Counters:
  - Bit-phase counter 0..CLOCKS_PER_BIT-1, wraps.
  - Bit counter width sized for 10.
  - State transitions occur only at the bit-time boundary.

Test Plan:
- Single word 0x155 -> tx_active high for 184 clocks. Sampled stream after code violation: sync 1, data 0101010101, parity 1, then END (0, high 16 clocks). ready low 1 cycle after accept, high again at SYNC entry.
- Word 0x000 -> parity bit 0. Each data bit decodes as low 4 clocks then high 4 clocks.
- Two words 0x3FF, 0x001 presented back-to-back -> second accepted when ready rises at first SYNC entry. One frame, one quiesce, one code violation. Parities 0 and 1. tx_active high 184+96=280 clocks.
- valid held high while in END -> no accept until IDLE. New frame begins with a full 5-bit quiesce.
- reset_n pulsed low during DATA bit 4 -> tx=0 and tx_active=0 asynchronously. ready=1 after release; no residual bits on the next frame.
- Instance with CLOCKS_PER_BIT=4, word 0x2AA -> frame length 92 clocks; code violation is 6 high then 6 low clocks.
